branch_resolve_unit: RTL and testbench

BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

---
 rtl/branch_resolve_unit.sv | 109 ++++++++++
 tb/tb_branch_resolve_unit.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_unit.sv
// Branch resolution unit: evaluates a branch condition, reports the prediction outcome to the
// condition register through a request/grant handshake, then presents the result to a consumer.
module branch_resolve_unit #(
    parameter int unsigned ID_WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [ID_WIDTH-1:0] in_issue_id,
    input  logic [31:0]         in_pc,
    input  logic [31:0]         in_rs_val,
    input  logic [31:0]         in_rt_val,
    input  logic [15:0]         in_imm16,
    input  logic [2:0]          in_cond,
    input  logic                in_pred_taken,
    output logic                ecr_req_write,
    output logic [ID_WIDTH-1:0] ecr_issue_id,
    output logic [1:0]          ecr_wdata,
    input  logic                ecr_grant,
    output logic                ecr_release_lock,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [ID_WIDTH-1:0] out_issue_id,
    output logic                out_taken,
    output logic                out_mispredict,
    output logic [31:0]         out_redirect_pc,
    output logic                busy
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StReq  = 2'd1;
    localparam logic [1:0] StRel  = 2'd2;
    localparam logic [1:0] StResp = 2'd3;

    logic [1:0]          state_q, state_d;
    logic [ID_WIDTH-1:0] id_q;
    logic                taken_q;
    logic                mispredict_q;
    logic [31:0]         redirect_q;

    logic                accept;
    logic                taken_d;
    logic [31:0]         target;
    logic [31:0]         fall_through;

    assign accept = in_valid && (state_q == StIdle);

    always_comb begin
        taken_d = 1'b0;
        unique case (in_cond)
            3'd0:    taken_d = (in_rs_val == in_rt_val);
            3'd1:    taken_d = (in_rs_val != in_rt_val);
            3'd2:    taken_d = ($signed(in_rs_val) <= 32'sd0);
            3'd3:    taken_d = ($signed(in_rs_val) > 32'sd0);
            3'd4:    taken_d = in_rs_val[31];
            3'd5:    taken_d = ~in_rs_val[31];
            default: taken_d = 1'b0;
        endcase
    end

    // Offset is in words; the delay slot makes the fall-through pc + 8.
    assign target       = in_pc + 32'd4 + {{14{in_imm16[15]}}, in_imm16, 2'b00};
    assign fall_through = in_pc + 32'd8;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (in_valid)  state_d = StReq;
            StReq:   if (ecr_grant) state_d = StRel;
            StRel:                  state_d = StResp;
            StResp:  if (out_ready) state_d = StIdle;
            default:                state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            id_q         <= '0;
            taken_q      <= 1'b0;
            mispredict_q <= 1'b0;
            redirect_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                id_q         <= in_issue_id;
                taken_q      <= taken_d;
                mispredict_q <= taken_d ^ in_pred_taken;
                redirect_q   <= taken_d ? target : fall_through;
            end
        end
    end

    // Gate with rst_n so in_ready is low for the whole reset window.
    assign in_ready         = rst_n && (state_q == StIdle);
    assign busy             = (state_q != StIdle);
    assign ecr_req_write    = (state_q == StReq);
    assign ecr_release_lock = (state_q == StRel);
    assign out_valid        = (state_q == StResp);

    assign ecr_issue_id    = id_q;
    assign ecr_wdata       = mispredict_q ? 2'b10 : 2'b01;
    assign out_issue_id    = id_q;
    assign out_taken       = taken_q;
    assign out_mispredict  = mispredict_q;
    assign out_redirect_pc = redirect_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: behavioural model with per-cycle compare plus
// directed branch scenarios with hand-computed expectations.
module tb_branch_resolve_unit;

    localparam int unsigned IW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [IW-1:0] in_issue_id;
    logic [31:0]   in_pc;
    logic [31:0]   in_rs_val;
    logic [31:0]   in_rt_val;
    logic [15:0]   in_imm16;
    logic [2:0]    in_cond;
    logic          in_pred_taken;
    logic          ecr_req_write;
    logic [IW-1:0] ecr_issue_id;
    logic [1:0]    ecr_wdata;
    logic          ecr_grant;
    logic          ecr_release_lock;
    logic          out_valid;
    logic          out_ready;
    logic [IW-1:0] out_issue_id;
    logic          out_taken;
    logic          out_mispredict;
    logic [31:0]   out_redirect_pc;
    logic          busy;

    always #5 clk = ~clk;

    branch_resolve_unit #(.ID_WIDTH(IW)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_issue_id      (in_issue_id),
        .in_pc            (in_pc),
        .in_rs_val        (in_rs_val),
        .in_rt_val        (in_rt_val),
        .in_imm16         (in_imm16),
        .in_cond          (in_cond),
        .in_pred_taken    (in_pred_taken),
        .ecr_req_write    (ecr_req_write),
        .ecr_issue_id     (ecr_issue_id),
        .ecr_wdata        (ecr_wdata),
        .ecr_grant        (ecr_grant),
        .ecr_release_lock (ecr_release_lock),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_issue_id     (out_issue_id),
        .out_taken        (out_taken),
        .out_mispredict   (out_mispredict),
        .out_redirect_pc  (out_redirect_pc),
        .busy             (busy)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Returns {taken, redirect_pc} computed from the architectural branch rules.
    function automatic logic [32:0] resolve(input logic [2:0] cond, input logic [31:0] rs,
                                            input logic [31:0] rt, input logic [31:0] pc,
                                            input logic [15:0] imm);
        int signed   a;
        logic        t;
        longint      tgt;
        logic [31:0] r;
        a = rs;
        case (cond)
            3'd0:    t = (rs == rt);
            3'd1:    t = (rs != rt);
            3'd2:    t = (a <= 0);
            3'd3:    t = (a > 0);
            3'd4:    t = (a < 0);
            3'd5:    t = (a >= 0);
            default: t = 1'b0;
        endcase
        tgt = longint'(pc) + 4 + longint'($signed(imm)) * 4;
        r   = t ? tgt[31:0] : pc + 32'd8;
        return {t, r};
    endfunction

    // Model: phase 0 idle, 1 requesting, 2 releasing, 3 responding.
    int            m_phase;
    logic [IW-1:0] m_id;
    logic          m_taken;
    logic          m_mis;
    logic [31:0]   m_redir;
    logic [32:0]   m_res;

    assign m_res = resolve(in_cond, in_rs_val, in_rt_val, in_pc, in_imm16);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase <= 0;
            m_id    <= '0;
            m_taken <= 1'b0;
            m_mis   <= 1'b0;
            m_redir <= '0;
        end else begin
            case (m_phase)
                0: if (in_valid) begin
                    m_phase <= 1;
                    m_id    <= in_issue_id;
                    m_taken <= m_res[32];
                    m_mis   <= m_res[32] ^ in_pred_taken;
                    m_redir <= m_res[31:0];
                end
                1: if (ecr_grant) m_phase <= 2;
                2: m_phase <= 3;
                default: if (out_ready) m_phase <= 0;
            endcase
        end
    end

    // Monitor captures for the directed literal checks.
    int            ncyc = 0;
    int            req_cnt = 0, rel_cnt = 0, val_cnt = 0;
    int            req_first = 0, rel_idx = 0, val_first = 0;
    logic          req_prev = 1'b0, val_prev = 1'b0;
    logic [1:0]    cap_wdata;
    logic [IW-1:0] cap_eid;
    logic          cap_taken, cap_mis;
    logic [31:0]   cap_redir;

    always @(negedge clk) begin
        check("in_ready", in_ready, rst_n && m_phase == 0);
        check("busy", busy, m_phase != 0);
        check("ecr_req_write", ecr_req_write, m_phase == 1);
        check("ecr_release_lock", ecr_release_lock, m_phase == 2);
        check("out_valid", out_valid, m_phase == 3);
        if (!rst_n) begin
            check("rst_out_issue_id", out_issue_id, 0);
            check("rst_out_redirect_pc", out_redirect_pc, 0);
        end
        if (m_phase == 1) begin
            check("ecr_issue_id", ecr_issue_id, m_id);
            check("ecr_wdata", ecr_wdata, m_mis ? 2'b10 : 2'b01);
        end
        if (m_phase == 3) begin
            check("out_issue_id", out_issue_id, m_id);
            check("out_taken", out_taken, m_taken);
            check("out_mispredict", out_mispredict, m_mis);
            check("out_redirect_pc", out_redirect_pc, m_redir);
        end
        if (ecr_req_write && !req_prev) req_first <= ncyc;
        req_prev <= ecr_req_write;
        if (ecr_req_write) begin
            req_cnt   <= req_cnt + 1;
            cap_wdata <= ecr_wdata;
            cap_eid   <= ecr_issue_id;
        end
        if (ecr_release_lock) begin
            rel_cnt <= rel_cnt + 1;
            rel_idx <= ncyc;
        end
        if (out_valid && !val_prev) val_first <= ncyc;
        val_prev <= out_valid;
        if (out_valid) begin
            val_cnt   <= val_cnt + 1;
            cap_taken <= out_taken;
            cap_mis   <= out_mispredict;
            cap_redir <= out_redirect_pc;
        end
        ncyc <= ncyc + 1;
    end

    int acc, b_req, b_rel, b_val;

    // One complete branch; gd = grant-low REQ edges, rd = ready-low RESP edges.
    task automatic run_op(input logic [IW-1:0] id, input logic [31:0] pc, input logic [31:0] rs,
                          input logic [31:0] rt, input logic [15:0] imm, input logic [2:0] cond,
                          input logic pred, input int gd, input int rd);
        @(negedge clk);
        #1;
        b_req = req_cnt;
        b_rel = rel_cnt;
        b_val = val_cnt;
        in_issue_id   = id;
        in_pc         = pc;
        in_rs_val     = rs;
        in_rt_val     = rt;
        in_imm16      = imm;
        in_cond       = cond;
        in_pred_taken = pred;
        in_valid      = 1'b1;
        ecr_grant     = 1'b1;
        out_ready     = 1'b1;
        @(posedge clk);
        #1;
        acc = ncyc;
        // Garbage on in_* while busy must be ignored, including a held in_valid.
        in_issue_id   = IW'($urandom);
        in_pc         = $urandom;
        in_rs_val     = $urandom;
        in_rt_val     = $urandom;
        in_imm16      = 16'($urandom);
        in_cond       = 3'($urandom);
        in_pred_taken = 1'($urandom);
        ecr_grant     = 1'b0;
        repeat (gd) begin
            @(posedge clk);
            #1;
        end
        ecr_grant = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        repeat (rd) begin
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        ecr_grant = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0; in_issue_id = '0; in_pc = '0; in_rs_val = '0; in_rt_val = '0;
        in_imm16 = '0; in_cond = '0; in_pred_taken = 1'b0; ecr_grant = 1'b1; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_rst", in_ready, 1);

        check("model_beq", resolve(3'd0, 32'd5, 32'd5, 32'h1000, 16'h0004), {1'b1, 32'h1014});
        check("model_wrap", resolve(3'd5, 32'd1, 32'd0, 32'h0, 16'hFFFF), {1'b1, 32'h0});

        run_op(8'd10, 32'h1000, 32'd5, 32'd5, 16'h0004, 3'd0, 1'b0, 0, 0);
        check("beq_wdata", cap_wdata, 2'b10);
        check("beq_eid", cap_eid, 10);
        check("beq_release_cnt", rel_cnt - b_rel, 1);
        check("beq_taken", cap_taken, 1);
        check("beq_mispredict", cap_mis, 1);
        check("beq_redirect", cap_redir, 32'h1014);
        check("beq_req_latency", req_first - acc, 0);
        check("beq_valid_latency", val_first - acc, 2);
        check("beq_resp_cycles", val_cnt - b_val, 1);

        run_op(8'd15, 32'h2000, 32'd7, 32'd7, 16'h0010, 3'd1, 1'b0, 0, 0);
        check("bne_wdata", cap_wdata, 2'b01);
        check("bne_taken", cap_taken, 0);
        check("bne_mispredict", cap_mis, 0);
        check("bne_redirect", cap_redir, 32'h2008);

        run_op(8'd33, 32'h5000, 32'd1, 32'd2, 16'h0008, 3'd0, 1'b1, 5, 0);
        check("stall_req_cycles", req_cnt - b_req, 6);
        check("stall_release_idx", rel_idx - acc, 6);
        check("stall_release_cnt", rel_cnt - b_rel, 1);
        check("stall_wdata", cap_wdata, 2'b10);
        check("stall_redirect", cap_redir, 32'h5008);

        run_op(8'd4, 32'h3000, 32'h8000_0000, 32'd0, 16'h0002, 3'd4, 1'b1, 0, 0);
        check("bltz_min_taken", cap_taken, 1);
        check("bltz_min_mispredict", cap_mis, 0);
        check("bltz_min_redirect", cap_redir, 32'h300C);

        run_op(8'd5, 32'h4000, 32'd0, 32'd9, 16'h0002, 3'd3, 1'b0, 0, 0);
        check("bgtz_zero_taken", cap_taken, 0);
        check("bgtz_zero_redirect", cap_redir, 32'h4008);

        run_op(8'd6, 32'h0, 32'd1, 32'd0, 16'hFFFF, 3'd5, 1'b1, 0, 0);
        check("wrap_target_taken", cap_taken, 1);
        check("wrap_target", cap_redir, 32'h0);

        run_op(8'd7, 32'hFFFF_FFFC, 32'd1, 32'd0, 16'h0040, 3'd2, 1'b0, 0, 0);
        check("wrap_fall_taken", cap_taken, 0);
        check("wrap_fall", cap_redir, 32'h4);

        run_op(8'd8, 32'h6000, 32'hFFFF_FFFF, 32'd0, 16'h0003, 3'd2, 1'b0, 0, 4);
        check("bp_resp_cycles", val_cnt - b_val, 5);
        check("bp_taken", cap_taken, 1);
        check("bp_redirect", cap_redir, 32'h6010);

        run_op(8'd9, 32'h7000, 32'd3, 32'd3, 16'h0001, 3'd6, 1'b1, 0, 0);
        check("reserved_taken", cap_taken, 0);
        check("reserved_mispredict", cap_mis, 1);
        check("reserved_redirect", cap_redir, 32'h7008);

        // Abort in REQ: no release pulse and no result from the aborted branch.
        @(negedge clk);
        #1;
        b_req = req_cnt;
        b_rel = rel_cnt;
        b_val = val_cnt;
        in_issue_id = 8'd77; in_pc = 32'h8000; in_rs_val = 32'd1; in_rt_val = 32'd1;
        in_imm16 = 16'h0004; in_cond = 3'd0; in_pred_taken = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        ecr_grant = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        ecr_grant = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        ecr_grant = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("abort_req_seen", req_cnt - b_req != 0, 1);
        check("abort_no_release", rel_cnt - b_rel, 0);
        check("abort_no_result", val_cnt - b_val, 0);

        run_op(8'd21, 32'h9000, 32'd0, 32'd5, 16'h0004, 3'd5, 1'b1, 0, 0);
        check("post_abort_wdata", cap_wdata, 2'b01);
        check("post_abort_eid", cap_eid, 21);
        check("post_abort_release_cnt", rel_cnt - b_rel, 1);
        check("post_abort_redirect", cap_redir, 32'h9014);

        repeat (3) @(posedge clk);
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
